cpu_memory_bridge: RTL
======================

Name: cpu_memory_bridge

Overview:
Memory-side bus controller that answers the CPU control unit's single-beat requests (cpu_addr/cpu_read/cpu_write) and returns cpu_rdata with a one-cycle cpu_ready pulse. It decodes the 16-bit address into RAM, ROM and I/O regions and drives the BSRAM RAM/ROM macros and the I/O peripheral page. It owns all wait-state generation, so the control unit's FETCH/DECODE/EXECUTE/MEMORY states stall purely on cpu_ready.

Parameters:
RAM_AW, 13, RAM word address width; RAM occupies 0x0000-0x7FFF, mirrored modulo 2^RAM_AW.
ROM_AW, 13, ROM address width; ROM occupies 0xE000-0xFFFF (low ROM_AW bits used).
MEM_LATENCY, 1, BSRAM read latency in cycles (1..3).
IO_TIMEOUT, 15, maximum cycles to wait for io_ack before erroring (1..255).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_addr  in  16  request address
cpu_wdata  in  8  write data
cpu_read  in  1  read request (level, held until cpu_ready)
cpu_write  in  1  write request (level, held until cpu_ready)
cpu_rdata  out  8  read data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
ram_addr  out  RAM_AW  RAM address
ram_ce  out  1  RAM strobe
ram_we  out  1  RAM write enable (qualifies ram_ce)
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, MEM_LATENCY cycles after ram_ce
rom_addr  out  ROM_AW  ROM address
rom_ce  out  1  ROM strobe
rom_rdata  in  8  ROM read data, MEM_LATENCY cycles after rom_ce
io_sel  out  1  I/O access active (held until io_ack or timeout)
io_addr  out  8  I/O register offset (cpu_addr[7:0])
io_we  out  1  I/O write
io_wdata  out  8  I/O write data
io_rdata  in  8  I/O read data, valid with io_ack
io_ack  in  1  I/O completion
bus_error  out  1  one-cycle pulse coincident with cpu_ready on an errored access

Behaviour:
- Reset: all outputs 0, FSM=IDLE, latched address/data cleared. Reset mid-transaction aborts it; no strobe is issued afterwards and no cpu_ready is produced.
- Region decode on the latched address: 0x0000-0x7FFF RAM; 0x8000-0x80FF IO; 0xE000-0xFFFF ROM; everything else UNMAPPED.
- FSM states: IDLE, MEM_WAIT, IO_WAIT, RESP.
- IDLE: if cpu_read|cpu_write in cycle T, latch addr, wdata and direction, then branch on region. RAM/ROM -> MEM_WAIT. IO -> IO_WAIT. UNMAPPED -> RESP.
- MEM_WAIT:
  - ram_ce/rom_ce is a single-cycle pulse in T+1, with ram_we/ram_wdata for writes.
  - Writes: RESP in T+2.
  - Reads: a down-counter waits MEM_LATENCY cycles, data is registered into cpu_rdata, then RESP. With MEM_LATENCY=1, cpu_ready is high in T+3.
- IO_WAIT:
  - io_sel, io_addr, io_we and io_wdata are held from T+1 until io_ack.
  - If io_ack arrives in cycle k, register io_rdata and go to RESP (cpu_ready in k+1).
  - Timeout counter starts at IO_TIMEOUT. At 0 with no ack, set cpu_rdata=0xFF and bus_error, then RESP.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE. Requests present during RESP are not sampled; the control unit advances on this ready. The earliest next acceptance is in the following cycle (IDLE).
- Write results:
  - Write to ROM: acknowledged, no rom_ce, bus_error=1.
  - Write to UNMAPPED: acknowledged, bus_error=1.
  - Read from UNMAPPED: cpu_rdata=0xFF, bus_error=1, ready in T+1.
- cpu_read and cpu_write both high: treated as write, bus_error=1.
- Request dropped mid-transaction: the transaction still completes and cpu_ready still pulses.
- cpu_rdata holds its last value outside RESP. On writes it is unchanged.
- Address mirroring: RAM uses cpu_addr[RAM_AW-1:0]; ROM uses cpu_addr[ROM_AW-1:0].

Decomposition:
- Package mem_map_pkg holds:
  - region enum (REG_RAM, REG_IO, REG_ROM, REG_UNMAPPED) and bridge FSM state typedef;
  - region base/limit constants (0x0000/0x7FFF, 0x8000/0x80FF, 0xE000/0xFFFF);
  - UNMAPPED_READ_VALUE=8'hFF.
- Sub-module mem_region_decoder: combinational address-to-region decode, shared with later DMA/debug masters.

Test Plan:
- RAM write then read: write 0x1234<-0xA5 -> ram_ce+ram_we in T+1, ram_addr=0x1234, ready in T+2. Read 0x1234 (RAM model returns 0xA5) -> cpu_rdata=0xA5, ready in T+3, bus_error=0.
- ROM reset-vector read: 0xFFFC with rom_rdata=0x00, then 0xFFFD with 0xE0 -> rdata 0x00 then 0xE0. Write to 0xFFFC -> ready, bus_error=1, rom_ce never asserted.
- IO read, ack after 4 cycles: read 0x8002 -> io_addr=0x02 held 4 cycles; io_rdata=0x5A -> cpu_rdata=0x5A, ready one cycle after ack.
- IO timeout, IO_TIMEOUT=3, io_ack never asserted: read 0x8001 -> cpu_rdata=0xFF, ready+bus_error pulse after timeout, io_sel deasserted.
- Unmapped and collision: read 0x9000 -> 0xFF, bus_error, ready in T+1. cpu_read=cpu_write=1 at 0x0010 with wdata 0x33 -> RAM write of 0x33, bus_error=1.
- Reset mid-read: assert rst_n=0 during MEM_WAIT -> all outputs 0 immediately, no cpu_ready. After release, a fresh read 0x0000 completes normally.

Source files
------------

// File: rtl/mem_map_pkg.sv
// ============================================================================
//  Module      : mem_map_pkg
//  Description : CPU memory map. Defines the region and bridge-state types,
//                the base/limit address of each region and the value returned
//                by reads that hit no region.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_map_pkg;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_IO       = 2'd1,
    REG_ROM      = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_IO_WAIT  = 2'd2,
    ST_RESP     = 2'd3
  } bridge_state_e;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_LIMIT = 16'h7FFF;
  localparam logic [15:0] IO_BASE   = 16'h8000;
  localparam logic [15:0] IO_LIMIT  = 16'h80FF;
  localparam logic [15:0] ROM_BASE  = 16'hE000;
  localparam logic [15:0] ROM_LIMIT = 16'hFFFF;

  localparam logic [7:0] UNMAPPED_READ_VALUE = 8'hFF;

  // Inclusive range test shared by every address decoder.
  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage : mem_map_pkg

`default_nettype wire

// File: rtl/mem_region_decoder.sv
// ============================================================================
//  Module      : mem_region_decoder
//  Description : Combinational 16-bit address to memory-region decode.
//                Usable by any bus master (CPU bridge, DMA, debug).
//  Ports       : addr_i   [15:0] address to classify
//                region_o        region_e of addr_i
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_region_decoder
  import mem_map_pkg::*;
(
  input  logic [15:0] addr_i,
  output region_e     region_o
);

  always_comb begin
    region_o = REG_UNMAPPED;
    if (in_range(addr_i, RAM_BASE, RAM_LIMIT)) begin
      region_o = REG_RAM;
    end else if (in_range(addr_i, IO_BASE, IO_LIMIT)) begin
      region_o = REG_IO;
    end else if (in_range(addr_i, ROM_BASE, ROM_LIMIT)) begin
      region_o = REG_ROM;
    end
  end

endmodule : mem_region_decoder

`default_nettype wire

// File: rtl/cpu_memory_bridge.sv
// ============================================================================
//  Module      : cpu_memory_bridge
//  Description : Single-beat CPU bus controller. Decodes the request address
//                into RAM / IO / ROM / unmapped, drives the BSRAM macros and
//                the I/O page, generates all wait states and returns a
//                one-cycle cpu_ready (with bus_error on faulted accesses).
//  Ports       : clk, rst_n             clock, async active-low reset
//                cpu_*                  CPU request / response
//                ram_*                  RAM macro (RAM_AW address bits)
//                rom_*                  ROM macro (ROM_AW address bits)
//                io_*                   I/O peripheral page handshake
//                bus_error              error flag, coincident with cpu_ready
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_memory_bridge
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_AW      = 13,
  parameter int unsigned ROM_AW      = 13,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned IO_TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_ce,
  input  logic [7:0]        rom_rdata,
  output logic              io_sel,
  output logic [7:0]        io_addr,
  output logic              io_we,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  input  logic              io_ack,
  output logic              bus_error
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY);
  localparam logic [7:0] TO_INIT  = 8'(IO_TIMEOUT);

  bridge_state_e state_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          we_q;
  logic          collide_q;
  logic [1:0]    lat_cnt_q;
  logic [7:0]    to_cnt_q;
  logic [7:0]    rdata_q;
  logic          ready_q;
  logic          err_q;
  logic          ram_ce_q;
  logic          ram_we_q;
  logic          rom_ce_q;
  logic          io_sel_q;
  logic          io_we_q;

  region_e req_region;
  region_e lat_region;

  // The branch out of IDLE needs the region of the incoming address in the
  // same cycle; later states use the region of the latched address.
  mem_region_decoder u_req_decode (
    .addr_i   (cpu_addr),
    .region_o (req_region)
  );

  mem_region_decoder u_lat_decode (
    .addr_i   (addr_q),
    .region_o (lat_region)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      collide_q <= 1'b0;
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      ram_ce_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      rom_ce_q  <= 1'b0;
      io_sel_q  <= 1'b0;
      io_we_q   <= 1'b0;
    end else begin
      // Strobes and the response are single-cycle pulses by default.
      ram_ce_q <= 1'b0;
      ram_we_q <= 1'b0;
      rom_ce_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_read || cpu_write) begin
            // Read+write collision is executed as a write and flagged.
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            we_q      <= cpu_write;
            collide_q <= cpu_read && cpu_write;
            lat_cnt_q <= LAT_INIT;
            to_cnt_q  <= TO_INIT;
            case (req_region)
              REG_RAM: begin
                ram_ce_q <= 1'b1;
                ram_we_q <= cpu_write;
                state_q  <= ST_MEM_WAIT;
              end
              REG_ROM: begin
                if (cpu_write) begin
                  // ROM is never strobed for a write; answer with an error.
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
                end else begin
                  rom_ce_q <= 1'b1;
                  state_q  <= ST_MEM_WAIT;
                end
              end
              REG_IO: begin
                io_sel_q <= 1'b1;
                io_we_q  <= cpu_write;
                state_q  <= ST_IO_WAIT;
              end
              default: begin
                if (!cpu_write) begin
                  rdata_q <= UNMAPPED_READ_VALUE;
                end
                ready_q <= 1'b1;
                err_q   <= 1'b1;
                state_q <= ST_RESP;
              end
            endcase
          end
        end

        ST_MEM_WAIT: begin
          if (we_q) begin
            ready_q <= 1'b1;
            err_q   <= collide_q;
            state_q <= ST_RESP;
          end else if (lat_cnt_q == 2'd0) begin
            rdata_q <= (lat_region == REG_ROM) ? rom_rdata : ram_rdata;
            ready_q <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end

        ST_IO_WAIT: begin
          // An ack in the same cycle the counter expires still wins.
          if (io_ack) begin
            if (!we_q) begin
              rdata_q <= io_rdata;
            end
            io_sel_q <= 1'b0;
            io_we_q  <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= collide_q;
            state_q  <= ST_RESP;
          end else if (to_cnt_q == 8'd0) begin
            if (!we_q) begin
              rdata_q <= UNMAPPED_READ_VALUE;
            end
            io_sel_q <= 1'b0;
            io_we_q  <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b1;
            state_q  <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_q - 8'd1;
          end
        end

        default: begin
          // ST_RESP: ready is high this cycle; requests are not sampled.
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign bus_error = err_q;
  assign ram_addr  = addr_q[RAM_AW-1:0];
  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = wdata_q;
  assign rom_addr  = addr_q[ROM_AW-1:0];
  assign rom_ce    = rom_ce_q;
  assign io_sel    = io_sel_q;
  assign io_addr   = addr_q[7:0];
  assign io_we     = io_we_q;
  assign io_wdata  = wdata_q;

endmodule : cpu_memory_bridge

`default_nettype wire
